// File: rtl/key_debounce.sv
// Push-button conditioner: two-flop synchroniser, stability-timed debounce FSM,
// registered level/press/release outputs. Optional auto-repeat: DEBOUNCE_AUTO_REPEAT_EN.
module key_debounce #(
  parameter int STABLE_CYCLES  = 250000,
  parameter int CNT_W          = 18,
  parameter int KEY_ACTIVE_LOW = 1,
  parameter int REPEAT_DELAY   = 25000000,
  parameter int REPEAT_PERIOD  = 5000000,
  parameter int REP_W          = 25
) (
  input  logic clock,
  input  logic clear,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    PRESSED,
    WAIT_RELEASE
  } state_t;

  localparam logic             IDLE_LEVEL = (KEY_ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(STABLE_CYCLES - 1);

  logic             sync_a;
  logic             sync_b;
  logic             k;
  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             level_next;
  logic             press_next;
  logic             release_next;

`ifdef DEBOUNCE_AUTO_REPEAT_EN
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0] rep_cnt;
  logic [REP_W-1:0] rep_next;
  logic             rep_phase;
  logic             phase_next;
  logic [REP_W-1:0] rep_last;

  // First repeat waits REPEAT_DELAY; later ones use REPEAT_PERIOD.
  assign rep_last = rep_phase ? PERIOD_LAST : DELAY_LAST;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would let sync_b see this edge's sync_a.
  always_ff @(posedge clock) begin
    if (!clear) begin
      sync_a <= IDLE_LEVEL;
      sync_b <= IDLE_LEVEL;
    end else begin
      sync_a <= key_in;
      sync_b <= sync_a;
    end
  end

  assign k = sync_b ^ IDLE_LEVEL;

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    level_next   = key_level;
    press_next   = 1'b0;
    release_next = 1'b0;
`ifdef DEBOUNCE_AUTO_REPEAT_EN
    rep_next     = rep_cnt;
    phase_next   = rep_phase;
`endif
    case (state)
      IDLE: begin
        level_next = 1'b0;
        if (k) begin
          state_next = WAIT_PRESS;
          cnt_next   = '0;
        end
      end
      WAIT_PRESS: begin
        level_next = 1'b0;
        if (!k) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = PRESSED;
          cnt_next   = '0;
          press_next = 1'b1;
          level_next = 1'b1;
`ifdef DEBOUNCE_AUTO_REPEAT_EN
          rep_next   = '0;
          phase_next = 1'b0;
`endif
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      PRESSED: begin
        level_next = 1'b1;
        if (!k) begin
          state_next = WAIT_RELEASE;
          cnt_next   = '0;
        end else begin
`ifdef DEBOUNCE_AUTO_REPEAT_EN
          if (rep_cnt == rep_last) begin
            press_next = 1'b1;
            rep_next   = '0;
            phase_next = 1'b1;
          end else begin
            rep_next = rep_cnt + REP_W'(1);
          end
`endif
        end
      end
      WAIT_RELEASE: begin
        level_next = 1'b1;
        // Bounce back to PRESSED keeps the repeat counter frozen.
        if (k) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next   = IDLE;
          cnt_next     = '0;
          release_next = 1'b1;
          level_next   = 1'b0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        level_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      state       <= IDLE;
      cnt         <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      key_level   <= level_next;
      key_press   <= press_next;
      key_release <= release_next;
    end
  end

`ifdef DEBOUNCE_AUTO_REPEAT_EN
  always_ff @(posedge clock) begin
    if (!clear) begin
      rep_cnt   <= '0;
      rep_phase <= 1'b0;
    end else begin
      rep_cnt   <= rep_next;
      rep_phase <= phase_next;
    end
  end
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Randomized bench for key_debounce: two instances (STABLE_CYCLES=4 active-low,
// STABLE_CYCLES=1 active-high) checked every cycle against a run-length model.
module tb_key_debounce;

  localparam int SC_A         = 4;
  localparam int SC_B         = 1;
  localparam int REP_DELAY    = 10;
  localparam int REP_PERIOD   = 3;

  logic clock = 1'b0;
  logic clear;
  logic key_in;
  logic key_in_n;
  logic level_a, press_a, rel_a;
  logic level_b, press_b, rel_b;

  assign key_in_n = ~key_in;

  always #5 clock = ~clock;

  key_debounce #(
    .STABLE_CYCLES(SC_A), .CNT_W(3), .KEY_ACTIVE_LOW(1),
    .REPEAT_DELAY(REP_DELAY), .REPEAT_PERIOD(REP_PERIOD), .REP_W(5)
  ) dut_a (
    .clock(clock), .clear(clear), .key_in(key_in),
    .key_level(level_a), .key_press(press_a), .key_release(rel_a)
  );

  key_debounce #(
    .STABLE_CYCLES(SC_B), .CNT_W(1), .KEY_ACTIVE_LOW(0),
    .REPEAT_DELAY(REP_DELAY), .REPEAT_PERIOD(REP_PERIOD), .REP_W(5)
  ) dut_b (
    .clock(clock), .clear(clear), .key_in(key_in_n),
    .key_level(level_b), .key_press(press_b), .key_release(rel_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: a level change is accepted once the synchronised key has disagreed
  // with the accepted level on STABLE_CYCLES+1 consecutive edges.
  int   stable_of[2] = '{SC_A, SC_B};
  logic low_of[2]    = '{1'b1, 1'b0};
  logic ms1[2], ms2[2], mlevel[2], mpress[2], mrel[2];
  int   mrun[2], mheld[2];
  int   presses_exp = 0;
  logic [3:0] q_cnt = '0;
  int   edge_no;

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      logic raw;
      logic kk;
      raw = (i == 0) ? key_in : key_in_n;
      if (!clear) begin
        ms1[i] = low_of[i]; ms2[i] = low_of[i];
        mlevel[i] = 1'b0; mpress[i] = 1'b0; mrel[i] = 1'b0;
        mrun[i] = 0; mheld[i] = 0;
      end else begin
        kk = ms2[i] ^ low_of[i];
        mpress[i] = 1'b0;
        mrel[i]   = 1'b0;
        if (kk != mlevel[i]) begin
          mrun[i]++;
          if (mrun[i] == stable_of[i] + 1) begin
            mlevel[i] = kk;
            mrun[i]   = 0;
            if (kk) begin
              mpress[i] = 1'b1;
              mheld[i]  = 0;
            end else begin
              mrel[i] = 1'b1;
            end
          end
        end else begin
`ifdef DEBOUNCE_AUTO_REPEAT_EN
          if (mlevel[i] && mrun[i] == 0) begin
            mheld[i]++;
            if (mheld[i] == REP_DELAY ||
                (mheld[i] > REP_DELAY && (mheld[i] - REP_DELAY) % REP_PERIOD == 0))
              mpress[i] = 1'b1;
          end
`endif
          mrun[i] = 0;
        end
        ms2[i] = ms1[i];
        ms1[i] = raw;
      end
      if (i == 0 && mpress[i]) presses_exp++;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
    edge_no++;
    if (press_a) q_cnt = q_cnt + 4'd1;
    check("level_a",   int'(level_a), int'(mlevel[0]));
    check("press_a",   int'(press_a), int'(mpress[0]));
    check("release_a", int'(rel_a),   int'(mrel[0]));
    check("level_b",   int'(level_b), int'(mlevel[1]));
    check("press_b",   int'(press_b), int'(mpress[1]));
    check("release_b", int'(rel_b),   int'(mrel[1]));
    check("exclusive_a", int'(press_a & rel_a), 0);
  endtask

  task automatic measure(input string tag, input int lat_a, input int lat_b, input logic want_press);
    int first_a, first_b;
    first_a = -1;
    first_b = -1;
    edge_no = -1;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (first_a < 0 && (want_press ? press_a : rel_a)) first_a = edge_no;
      if (first_b < 0 && (want_press ? press_b : rel_b)) first_b = edge_no;
    end
    check({tag, "_a"}, first_a, lat_a);
    check({tag, "_b"}, first_b, lat_b);
  endtask

  initial begin
    int target;
    edge_no = 0;
    clear  = 1'b0;
    key_in = 1'b1;
    repeat (3) tick();
    check("rst_level", int'(level_a), 0);
    check("rst_press", int'(press_a), 0);
    check("rst_release", int'(rel_a), 0);
    clear = 1'b1;
    repeat (4) tick();

    // Clean press then clean release: edge index of the pulse.
    key_in = 1'b0;
    measure("press_latency", SC_A + 2, SC_B + 2, 1'b1);
    key_in = 1'b1;
    measure("release_latency", SC_A + 2, SC_B + 2, 1'b0);

    // Clear held during WAIT_PRESS with key down: debounce re-runs afterwards.
    key_in = 1'b0;
    repeat (4) tick();
    clear = 1'b0;
    repeat (3) tick();
    check("midrst_level", int'(level_a), 0);
    clear = 1'b1;
    measure("press_after_clear", SC_A + 2, SC_B + 2, 1'b1);
    key_in = 1'b1;
    repeat (12) tick();

    for (int n = 0; n < 80; n++) begin
      target = int'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) begin
        key_in = target[0];
        repeat ($urandom_range(1, 3)) tick();
        key_in = ~target[0];
        repeat ($urandom_range(1, 2)) tick();
      end
      key_in = target[0];
      if ($urandom_range(0, 7) == 0) repeat (45) tick();
      else repeat ($urandom_range(0, 15)) tick();
      if ($urandom_range(0, 9) == 0) begin
        clear = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
        clear = 1'b1;
      end
    end

    key_in = 1'b1;
    repeat (20) tick();
    check("q_count", int'(q_cnt), presses_exp % 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
